// File: rtl/dds_pkg.sv
// Shared constants for the DDS sweep controller: default widths, FSM state encodings
// and the frequency word loaded at reset.
package dds_pkg;

  localparam int FW_DEF = 21;
  localparam int DW_DEF = 16;

  localparam logic [1:0] SW_IDLE = 2'd0;
  localparam logic [1:0] SW_UP   = 2'd1;
  localparam logic [1:0] SW_DN   = 2'd2;
  localparam logic [1:0] SW_DONE = 2'd3;

  localparam logic [FW_DEF-1:0] F_RESET = '0;

endpackage

// File: rtl/dds_step_alu.sv
// Clamped step adder/subtractor: next = min(cur+step, limit) going up, or
// max(cur-step, limit) going down. Carry or borrow saturates to the limit.
module dds_step_alu
  import dds_pkg::*;
#(
  parameter int FW = FW_DEF
) (
  input  logic [FW-1:0] cur,
  input  logic [FW-1:0] step,
  input  logic [FW-1:0] limit,
  input  logic          dir_down,
  output logic [FW-1:0] next,
  output logic          at_limit
);

  logic [FW:0] sum;
  logic [FW:0] diff;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    next = limit;
    if (dir_down) begin
      if (!diff[FW] && (diff[FW-1:0] > limit)) next = diff[FW-1:0];
    end else begin
      if (!sum[FW] && (sum[FW-1:0] < limit)) next = sum[FW-1:0];
    end
  end

  assign at_limit = (cur == limit);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Staircase frequency sweep from a start word to a stop word with a programmable dwell.
// Define DDS_SWEEP_TRIANGLE_EN to sweep back down to the start word before finishing.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          repeat_en,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] f_control,
  output logic          f_update,
  output logic          busy,
  output logic          sweep_done
);

  logic [1:0]    state;
  logic [DW-1:0] cnt;
  logic [FW-1:0] sh_start;
  logic [FW-1:0] sh_stop;
  logic [FW-1:0] sh_step;
  logic [DW-1:0] sh_dwell;

  logic          dir_down;
  logic [FW-1:0] alu_next;
  logic          at_limit;
  logic          degenerate;
  logic          finish;
  logic [1:0]    step_state;
  logic          do_capture;

`ifdef DDS_SWEEP_TRIANGLE_EN
  // Turn around as soon as the current word sits on the stop word.
  assign dir_down   = (state == SW_DN) || (f_control == sh_stop);
  assign finish     = degenerate || ((state == SW_DN) && at_limit);
  assign step_state = dir_down ? SW_DN : SW_UP;
`else
  assign dir_down   = 1'b0;
  assign finish     = degenerate || at_limit;
  assign step_state = SW_UP;
`endif

  assign degenerate = (sh_start >= sh_stop) || (sh_step == '0);
  assign do_capture = !stop && (((state == SW_IDLE) && start) ||
                                ((state == SW_DONE) && repeat_en));

  dds_step_alu #(.FW(FW)) u_alu (
    .cur      (f_control),
    .step     (sh_step),
    .limit    (dir_down ? sh_start : sh_stop),
    .dir_down (dir_down),
    .next     (alu_next),
    .at_limit (at_limit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: shadow registers are reset too, so a stray read after reset is deterministic.
      state      <= SW_IDLE;
      cnt        <= '0;
      sh_start   <= '0;
      sh_stop    <= '0;
      sh_step    <= '0;
      sh_dwell   <= '0;
      f_control  <= FW'(F_RESET);
      f_update   <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      f_update   <= 1'b0;
      sweep_done <= 1'b0;
      if (do_capture) begin
        sh_start  <= f_start;
        sh_stop   <= f_stop;
        sh_step   <= f_step;
        sh_dwell  <= dwell;
        f_control <= f_start;
        cnt       <= dwell;
        f_update  <= 1'b1;
        busy      <= 1'b1;
        state     <= SW_UP;
      end else begin
        case (state)
          SW_IDLE: ;
          SW_UP, SW_DN: begin
            if (stop) begin
              state <= SW_IDLE;
              busy  <= 1'b0;
            end else if (cnt != '0) begin
              cnt <= cnt - DW'(1);
            end else if (finish) begin
              state      <= SW_DONE;
              sweep_done <= 1'b1;
            end else begin
              f_control <= alu_next;
              cnt       <= sh_dwell;
              f_update  <= 1'b1;
              state     <= step_state;
            end
          end
          default: begin
            state <= SW_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus pushes expected update/done events,
// a monitor pops them on every f_update or sweep_done pulse and checks value and spacing.
module tb_dds_sweep_ctrl;

  localparam int FW = 21;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          repeat_en;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_stop;
  logic [FW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic [FW-1:0] f_control;
  logic          f_update;
  logic          busy;
  logic          sweep_done;

  typedef struct {
    bit          is_done;
    logic [31:0] val;
    int          gap;
  } evt_t;

  evt_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   last_evt = 0;

  dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .repeat_en  (repeat_en),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_step     (f_step),
    .dwell      (dwell),
    .f_control  (f_control),
    .f_update   (f_update),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic push_upd(input logic [31:0] v, input int gap);
    evt_t e;
    e.is_done = 1'b0;
    e.val     = v;
    e.gap     = gap;
    sb.push_back(e);
  endtask

  task automatic push_done(input int gap);
    evt_t e;
    e.is_done = 1'b1;
    e.val     = '0;
    e.gap     = gap;
    sb.push_back(e);
  endtask

  // Monitor: compares every observed event against the head of the scoreboard.
  task automatic handle(input bit is_done);
    evt_t e;
    if (sb.size() == 0) begin
      check(1'b0, is_done ? "sb_unexpected_done" : "sb_unexpected_update",
            32'(f_control), 32'(0));
    end else begin
      e = sb.pop_front();
      check(e.is_done == is_done, "sb_kind", 32'(is_done), 32'(e.is_done));
      if (!is_done) check(32'(f_control) == e.val, "sb_value", 32'(f_control), e.val);
      if (e.gap != 0) check(cyc - last_evt == e.gap, "sb_gap", 32'(cyc - last_evt), 32'(e.gap));
    end
    last_evt = cyc;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (f_update)   handle(1'b0);
        if (sweep_done) handle(1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                           input logic [FW-1:0] st, input logic [DW-1:0] dw);
    f_start = fs;
    f_stop  = fe;
    f_step  = st;
    dwell   = dw;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start edge until busy is low; bounded.
  task automatic wait_idle(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max);
    if (busy) check(1'b0, "wait_idle_timeout", 32'(n), 32'(max));
  endtask

  int n;
  int k;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (2) @(posedge clk);
    #1;
    check(f_control == '0, "rst_f_control", 32'(f_control), 32'(0));
    check(f_update == 1'b0, "rst_f_update", 32'(f_update), 32'(0));
    check(busy == 1'b0, "rst_busy", 32'(busy), 32'(0));
    check(sweep_done == 1'b0, "rst_sweep_done", 32'(sweep_done), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Basic ramp 100..130 step 10 dwell 2.
    push_upd(100, 0); push_upd(110, 3); push_upd(120, 3); push_upd(130, 3);
`ifdef DDS_SWEEP_TRIANGLE_EN
    push_upd(120, 3); push_upd(110, 3); push_upd(100, 3);
`endif
    push_done(3);
    run_sweep(100, 130, 10, 2);
    wait_idle(60, n);
`ifdef DDS_SWEEP_TRIANGLE_EN
    check(n == 23, "ramp_busy_fall", 32'(n), 32'(23));
    check(f_control == 100, "ramp_final", 32'(f_control), 32'(100));
`else
    check(n == 14, "ramp_busy_fall", 32'(n), 32'(14));
    check(f_control == 130, "ramp_final", 32'(f_control), 32'(130));
`endif

    // Clamp at a stop word that is not on the step grid.
    push_upd(100, 0); push_upd(110, 3); push_upd(120, 3); push_upd(125, 3);
`ifdef DDS_SWEEP_TRIANGLE_EN
    push_upd(115, 3); push_upd(105, 3); push_upd(100, 3);
`endif
    push_done(3);
    run_sweep(100, 125, 10, 2);
    wait_idle(60, n);
`ifdef DDS_SWEEP_TRIANGLE_EN
    check(n == 23, "clamp_busy_fall", 32'(n), 32'(23));
`else
    check(n == 14, "clamp_busy_fall", 32'(n), 32'(14));
`endif

    // Carry out of the top bit saturates to the stop word.
    push_upd(32'h1FFFF0, 0); push_upd(32'h1FFFFF, 1);
`ifdef DDS_SWEEP_TRIANGLE_EN
    push_upd(32'h1FFFF0, 1);
`endif
    push_done(1);
    run_sweep(21'h1FFFF0, 21'h1FFFFF, 21'h20, 0);
    wait_idle(20, n);
`ifdef DDS_SWEEP_TRIANGLE_EN
    check(n == 5, "ovf_busy_fall", 32'(n), 32'(5));
    check(f_control == 21'h1FFFF0, "ovf_final", 32'(f_control), 32'h1FFFF0);
`else
    check(n == 4, "ovf_busy_fall", 32'(n), 32'(4));
    check(f_control == 21'h1FFFFF, "ovf_final", 32'(f_control), 32'h1FFFFF);
`endif

    // Degenerate configurations: start >= stop, then step == 0.
    push_upd(50, 0); push_done(4);
    run_sweep(50, 50, 10, 3);
    wait_idle(20, n);
    check(n == 6, "deg_eq_busy_fall", 32'(n), 32'(6));
    push_upd(10, 0); push_done(2);
    run_sweep(10, 100, 0, 1);
    wait_idle(20, n);
    check(n == 4, "deg_step0_busy_fall", 32'(n), 32'(4));

    // Abort during the 110 point.
    push_upd(100, 0); push_upd(110, 3);
    run_sweep(100, 130, 10, 2);
    k = 0;
    while (f_control != 110 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(f_control == 110, "abort_reach_110", 32'(f_control), 32'(110));
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check(busy == 1'b0, "abort_busy", 32'(busy), 32'(0));
    check(f_control == 110, "abort_hold", 32'(f_control), 32'(110));
    repeat (15) @(negedge clk);
    check(f_control == 110, "abort_hold_late", 32'(f_control), 32'(110));

    // Repeat: one automatic restart, then let the second pass finish.
    for (int p = 0; p < 2; p++) begin
      push_upd(100, (p == 0) ? 0 : 1); push_upd(110, 3); push_upd(120, 3); push_upd(130, 3);
`ifdef DDS_SWEEP_TRIANGLE_EN
      push_upd(120, 3); push_upd(110, 3); push_upd(100, 3);
`endif
      push_done(3);
    end
    repeat_en = 1'b1;
    run_sweep(100, 130, 10, 2);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sweep_done && k < 60);
    check(sweep_done == 1'b1, "repeat_first_done", 32'(sweep_done), 32'(1));
    @(posedge clk);
    #1 repeat_en = 1'b0;
    check(busy == 1'b1, "repeat_busy_kept", 32'(busy), 32'(1));
    wait_idle(60, n);
`ifdef DDS_SWEEP_TRIANGLE_EN
    check(f_control == 100, "repeat_final", 32'(f_control), 32'(100));
`else
    check(f_control == 130, "repeat_final", 32'(f_control), 32'(130));
`endif

    // Asynchronous reset in the middle of a dwell, away from any clock edge.
    push_upd(100, 0);
    run_sweep(100, 130, 10, 2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check(f_control == '0, "areset_f_control", 32'(f_control), 32'(0));
    check(busy == 1'b0, "areset_busy", 32'(busy), 32'(0));
    check(f_update == 1'b0, "areset_f_update", 32'(f_update), 32'(0));
    check(sweep_done == 1'b0, "areset_sweep_done", 32'(sweep_done), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // start together with stop in IDLE must not launch a sweep.
    f_start = 77;
    start   = 1'b1;
    stop    = 1'b1;
    @(posedge clk);
    #1;
    check(busy == 1'b0, "start_stop_busy", 32'(busy), 32'(0));
    check(f_control == '0, "start_stop_f_control", 32'(f_control), 32'(0));
    start = 1'b0;
    stop  = 1'b0;

    repeat (5) @(negedge clk);
    check(sb.size() == 0, "sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
